// File: rtl/multi_sum_pkg.sv
// ============================================================================
//  Module  : multi_sum_pkg
//  Purpose : Shared constants, types and helpers for the N-input FIFO adder.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package multi_sum_pkg;

    // Upper bound on the number of operand channels
    localparam int MAX_INPUTS = 8;

    // Result treatment when the reduced sum exceeds the output width
    typedef enum logic {
        SUM_WRAP = 1'b0,
        SUM_SAT  = 1'b1
    } sum_mode_e;

    // Width that holds the sum of n unsigned width-bit operands without loss
    function automatic int sum_ext_width(input int width, input int n);
        return width + $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/double_buffer_from_dally_harting.sv
// ============================================================================
//  Module  : double_buffer_from_dally_harting
//  Purpose : Two-slot elastic buffer (output register plus skid register);
//            full throughput, in-order, stalls upstream only when both full.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module double_buffer_from_dally_harting #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // The skid slot being occupied is exactly the both-slots-full condition
    assign up_ready   = ~r_skid_valid;
    assign down_valid = r_main_valid;
    assign down_data  = r_main_data;

    // Main slot drives the sink; skid slot absorbs one word while main stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (r_skid_valid) begin
            if (down_ready) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (!r_main_valid || down_ready) begin
            r_main_valid <= up_valid;
            if (up_valid) begin
                r_main_data <= up_data;
            end
        end else if (up_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= up_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/flip_flop_fifo_with_counter.sv
// ============================================================================
//  Module  : flip_flop_fifo_with_counter
//  Purpose : Register-based FIFO with occupancy counter; registered read data,
//            no write-to-read bypass.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module flip_flop_fifo_with_counter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] pop_data
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A push is only honoured when space exists, so a full FIFO drops nothing
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap at the last entry; counter tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_operand_adder.sv
// ============================================================================
//  Module  : multi_operand_adder
//  Purpose : Combinational N-operand unsigned reduction with optional
//            saturation; overflow bit optionally appended above the sum.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module multi_operand_adder
    import multi_sum_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N        = 3,
    parameter int SATURATE = 0,
    parameter int OVF_EN   = 0
) (
    input  logic [N*WIDTH-1:0]      operands,
    output logic [WIDTH+OVF_EN-1:0] result
);

    localparam int        c_ext_w = sum_ext_width(WIDTH, N);
    localparam sum_mode_e c_mode  = (SATURATE != 0) ? SUM_SAT : SUM_WRAP;

    logic [c_ext_w-1:0] w_full;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_sum;

    // Reduce at the extended width so no carry is lost before the ovf check
    always_comb begin
        w_full = '0;
        for (int i = 0; i < N && i < MAX_INPUTS; i++) begin
            w_full = w_full + c_ext_w'(operands[i*WIDTH +: WIDTH]);
        end
    end

    // Any bit above the output width means the true sum does not fit
    assign w_ovf = |w_full[c_ext_w-1:WIDTH];
    assign w_sum = (c_mode == SUM_SAT && w_ovf) ? '1 : w_full[WIDTH-1:0];

    generate
        if (OVF_EN != 0) begin : g_ovf
            assign result = {w_ovf, w_sum};
        end else begin : g_no_ovf
            assign result = w_sum;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/multi_sum_using_fifos_and_double_buffer.sv
// ============================================================================
//  Module  : multi_sum_using_fifos_and_double_buffer
//  Purpose : N independent operand FIFOs joined into one reduced sum that is
//            delivered through a two-slot double buffer to a valid/ready sink.
//            Define MULTI_SUM_OVERFLOW_FLAG_EN to add the sum_overflow port.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module multi_sum_using_fifos_and_double_buffer
    import multi_sum_pkg::*;
#(
    parameter int width    = 8,
    parameter int depth    = 10,
    parameter int n_inputs = 3,
    parameter int saturate = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_inputs-1:0]       in_valid,
    output logic [n_inputs-1:0]       in_ready,
    input  logic [n_inputs*width-1:0] in_data,
    output logic                      sum_valid,
    input  logic                      sum_ready,
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
    output logic                      sum_overflow,
`endif
    output logic [width-1:0]          sum_data
);

`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
    localparam int c_ovf_en = 1;
`else
    localparam int c_ovf_en = 0;
`endif
    localparam int c_buf_w = width + c_ovf_en;

    logic [n_inputs-1:0]       w_full;
    logic [n_inputs-1:0]       w_empty;
    logic [n_inputs*width-1:0] w_heads;
    logic                      w_join_valid;
    logic                      w_join_fire;
    logic                      w_buf_up_ready;
    logic [c_buf_w-1:0]        w_result;
    logic [c_buf_w-1:0]        w_buf_out;

    // Join only when every channel has a word, and pop all of them together
    assign w_join_valid = &(~w_empty);
    assign w_join_fire  = w_join_valid & w_buf_up_ready;

    generate
        for (genvar i = 0; i < n_inputs; i++) begin : g_fifo
            assign in_ready[i] = ~w_full[i] & rst;

            flip_flop_fifo_with_counter #(
                .WIDTH (width),
                .DEPTH (depth)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (in_valid[i] & in_ready[i]),
                .push_data (in_data[i*width +: width]),
                .pop       (w_join_fire),
                .full      (w_full[i]),
                .empty     (w_empty[i]),
                .pop_data  (w_heads[i*width +: width])
            );
        end
    endgenerate

    multi_operand_adder #(
        .WIDTH    (width),
        .N        (n_inputs),
        .SATURATE (saturate),
        .OVF_EN   (c_ovf_en)
    ) u_adder (
        .operands (w_heads),
        .result   (w_result)
    );

    double_buffer_from_dally_harting #(
        .WIDTH (c_buf_w)
    ) u_dbuf (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (w_join_valid),
        .up_ready   (w_buf_up_ready),
        .up_data    (w_result),
        .down_valid (sum_valid),
        .down_ready (sum_ready),
        .down_data  (w_buf_out)
    );

    assign sum_data = w_buf_out[width-1:0];
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
    assign sum_overflow = w_buf_out[width];
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_sum_using_fifos_and_double_buffer.sv
// ============================================================================
//  Module  : tb_multi_sum_using_fifos_and_double_buffer
//  Purpose : Bench for the N-input FIFO adder; a wrapping and a saturating
//            instance share all stimulus and are scored against queue models.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_sum_using_fifos_and_double_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  in_ready_s;
    logic [23:0] in_data;
    logic        sum_ready;
    logic        sum_valid;
    logic        sum_valid_s;
    logic [7:0]  sum_data;
    logic [7:0]  sum_data_s;
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
    logic        sum_overflow;
    logic        sum_overflow_s;
    int          q_ovf[$];
`endif

    int total = 0;
    int bad   = 0;
    int chq[3][$];
    int q_wrap[$];
    int q_sat[$];
    int acc[3] = '{0, 0, 0};
    int n_out  = 0;

    always #5 clk = ~clk;

    multi_sum_using_fifos_and_double_buffer #(
        .width(8), .depth(10), .n_inputs(3), .saturate(0)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
        .sum_overflow(sum_overflow),
`endif
        .sum_data(sum_data)
    );

    multi_sum_using_fifos_and_double_buffer #(
        .width(8), .depth(10), .n_inputs(3), .saturate(1)
    ) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .sum_valid(sum_valid_s), .sum_ready(sum_ready),
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
        .sum_overflow(sum_overflow_s),
`endif
        .sum_data(sum_data_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: accepted words queue per channel; join whenever all
    // channels hold a word; outputs are popped and compared on each transfer.
    always @(negedge clk) begin
        int s;
        if (rst === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    chq[i].push_back(int'(in_data[i*8 +: 8]));
                    acc[i]++;
                end
            end
            while (chq[0].size() > 0 && chq[1].size() > 0 && chq[2].size() > 0) begin
                s = chq[0].pop_front() + chq[1].pop_front() + chq[2].pop_front();
                q_wrap.push_back(s % 256);
                q_sat.push_back((s > 255) ? 255 : s);
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
                q_ovf.push_back((s > 255) ? 1 : 0);
`endif
            end
            if (sum_valid && sum_ready) begin
                n_out++;
                chk("wrap_out_expected", (q_wrap.size() != 0), 1);
                if (q_wrap.size() != 0) begin
                    chk("wrap_out_data", sum_data, q_wrap.pop_front());
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
                    chk("wrap_out_ovf", sum_overflow, q_ovf.pop_front());
`endif
                end
            end
            if (sum_valid_s && sum_ready) begin
                chk("sat_out_expected", (q_sat.size() != 0), 1);
                if (q_sat.size() != 0) begin
                    chk("sat_out_data", sum_data_s, q_sat.pop_front());
                end
            end
        end
    end

    task automatic push3(input int a, input int b, input int c,
                         input int exp_w, input int exp_s, input int exp_o);
        @(posedge clk); #1;
        in_valid = 3'b111;
        in_data  = {8'(c), 8'(b), 8'(a)};
        @(posedge clk); #1;
        in_valid = 3'b000;
        @(negedge clk);
        chk("lat1_valid", sum_valid, 0);
        @(negedge clk);
        chk("lat2_valid", sum_valid, 1);
        chk("lat2_wrap", sum_data, exp_w);
        chk("lat2_sat", sum_data_s, exp_s);
`ifdef MULTI_SUM_OVERFLOW_FLAG_EN
        chk("lat2_ovf", sum_overflow, exp_o);
        chk("lat2_ovf_sat", sum_overflow_s, exp_o);
`else
        if (exp_o < 0) chk("lat2_ovf_unused", exp_o, 0);
`endif
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q_wrap.size() != 0 || q_sat.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (q_wrap.size() == 0 && q_sat.size() == 0), 1);
    endtask

    initial begin
        int out0;
        int acc0;
        rst       = 1'b0;
        in_valid  = 3'b111;
        in_data   = 24'h030201;
        sum_ready = 1'b1;

        // Reset held for three cycles with all channels asserting valid
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 3'b000);
            chk("rst_sum_valid", sum_valid, 0);
            chk("rst_sum_data", sum_data, 0);
            chk("rst_sum_valid_sat", sum_valid_s, 0);
            @(posedge clk);
        end
        #1;
        rst      = 1'b1;
        in_valid = 3'b000;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 3'b111);

        // Directed sums with two-cycle latency
        push3(10, 20, 30, 60, 60, 0);
        push3(200, 100, 50, 94, 255, 1);
        push3(1, 2, 3, 6, 6, 0);
        push3(255, 255, 255, 253, 255, 1);
        drain("directed_drain");

        // Skew: fill channel 0 alone, then stream the other two
        out0 = n_out;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = 3'b001;
            in_data  = {8'd0, 8'd0, 8'(k + 1)};
        end
        @(posedge clk); #1;
        in_valid = 3'b000;
        @(negedge clk);
        chk("skew_ch0_full", in_ready, 3'b110);
        chk("skew_no_sum", sum_valid, 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = 3'b110;
            in_data  = {8'(3 * k), 8'(20 + k), 8'd0};
        end
        @(posedge clk); #1;
        in_valid = 3'b000;
        drain("skew_drain");
        chk("skew_count", n_out - out0, 10);

        // Backpressure: sink stalled while all channels stream
        out0 = n_out;
        acc0 = acc[0];
        @(posedge clk); #1;
        sum_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 3'b111;
            in_data  = {8'(7 * k + 100), 8'(5 * k + 40), 8'(k * 11)};
            @(posedge clk); #1;
        end
        in_valid = 3'b000;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 3'b000);
        chk("bp_sum_valid", sum_valid, 1);
        chk("bp_accepted", acc[0] - acc0, 12);
        chk("bp_pending", q_wrap.size(), 12);
        chk("bp_stable_data", sum_data, (q_wrap.size() != 0) ? q_wrap[0] : -1);
        @(posedge clk); #1;
        sum_ready = 1'b1;
        drain("bp_drain");
        chk("bp_count", n_out - out0, 12);

        // Random valid/ready traffic
        out0 = n_out;
        acc0 = acc[1];
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk); #1;
            in_valid  = 3'($urandom);
            in_data   = 24'($urandom);
            sum_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 3'b000;
        sum_ready = 1'b1;
        drain("rand_drain");
        @(negedge clk);
        chk("rand_idle", sum_valid, 0);
        chk("rand_progress", (n_out - out0) > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
